flag_unit: RTL

- Producer/owner side of the NZCV condition-flag interface for the ARM-subset CPU control path.
- Generates N, Z, C, V from the Execute-stage ALU result and operands, and holds them in the architectural flag register.
- Evaluates the instruction condition field against the registered flags and gates the PC-source, register-write and memory-write strobes.
- Sits between the main decoder and the datapath, alongside the ALU.

---
 rtl/flag_unit_pkg.sv | 41 ++++
 rtl/flag_unit_cond_eval.sv | 46 ++++
 rtl/flag_unit.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/flag_unit_pkg.sv
// flag_unit_pkg
// Shared control-path types for the NZCV condition-flag logic.
//   cond_e     : instruction condition field encodings (EQ..AL, NV = 1111)
//   alu_ctrl_e : ALU operation select (ADD, SUB, AND, ORR)
//   flags_t    : packed {n, z, c, v} condition-flag word
package flag_unit_pkg;

   typedef enum logic [3:0] {
      EQ = 4'b0000,
      NE = 4'b0001,
      CS = 4'b0010,
      CC = 4'b0011,
      MI = 4'b0100,
      PL = 4'b0101,
      VS = 4'b0110,
      VC = 4'b0111,
      HI = 4'b1000,
      LS = 4'b1001,
      GE = 4'b1010,
      LT = 4'b1011,
      GT = 4'b1100,
      LE = 4'b1101,
      AL = 4'b1110,
      NV = 4'b1111
   } cond_e;

   typedef enum logic [1:0] {
      ADD = 2'b00,
      SUB = 2'b01,
      AND = 2'b10,
      ORR = 2'b11
   } alu_ctrl_e;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } flags_t;

endpackage

// File: rtl/flag_unit_cond_eval.sv
// cond_eval
// Purely combinational condition check of an instruction's condition field
// against the architectural flags.
//   cond    : condition field
//   flags   : current {n, z, c, v}
//   cond_ex : condition passed
//   undef   : condition field is the reserved 1111 encoding (ungated)
module cond_eval
   import flag_unit_pkg::*;
(
   input  cond_e  cond,
   input  flags_t flags,
   output logic   cond_ex,
   output logic   undef
);

   logic ge;

   // Signed-compare conditions all derive from GE = (N == V); the reserved
   // encoding never passes and is reported separately so the top can gate it.
   always_comb begin
      ge      = (flags.n == flags.v);
      cond_ex = 1'b0;
      undef   = 1'b0;
      case (cond)
         EQ:      cond_ex = flags.z;
         NE:      cond_ex = ~flags.z;
         CS:      cond_ex = flags.c;
         CC:      cond_ex = ~flags.c;
         MI:      cond_ex = flags.n;
         PL:      cond_ex = ~flags.n;
         VS:      cond_ex = flags.v;
         VC:      cond_ex = ~flags.v;
         HI:      cond_ex = flags.c & ~flags.z;
         LS:      cond_ex = ~(flags.c & ~flags.z);
         GE:      cond_ex = ge;
         LT:      cond_ex = ~ge;
         GT:      cond_ex = ~flags.z & ge;
         LE:      cond_ex = ~(~flags.z & ge);
         AL:      cond_ex = 1'b1;
         NV:      undef   = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end

endmodule

// File: rtl/flag_unit.sv
// flag_unit
// Owner of the NZCV flag register: computes flags from the Execute-stage ALU,
// holds them architecturally, evaluates the condition field and gates the
// decoder's PC-source / register-write / memory-write strobes.
// Ports:
//   clk, reset          : clock and asynchronous active-high reset
//   en, flush           : stage enable (0 = stall) and Execute squash
//   cond, flag_w        : condition field and {update NZ, update CV}
//   alu_ctrl            : ALU operation of the current instruction
//   src_a, src_b        : ALU operands (src_b before any inversion)
//   alu_result, alu_cout: ALU result and carry out
//   pcs, reg_w, mem_w   : decoder strobe requests
//   no_write            : compare-type op, never writes the register file
//   pc_src, reg_write, mem_write : gated strobes (registered if PIPE_OUT)
//   cond_ex, undef      : condition passed / reserved condition encoding
//   flags               : registered {N, Z, C, V}
//   annul_cnt           : saturating count of annulled instructions
module flag_unit
   import flag_unit_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int PIPE_OUT = 0,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             flush,
   input  logic [3:0]       cond,
   input  logic [1:0]       flag_w,
   input  logic [1:0]       alu_ctrl,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_cout,
   input  logic             pcs,
   input  logic             reg_w,
   input  logic             mem_w,
   input  logic             no_write,
   output logic             pc_src,
   output logic             reg_write,
   output logic             mem_write,
   output logic             cond_ex,
   output logic             undef,
   output logic [3:0]       flags,
   output logic [CNT_W-1:0] annul_cnt
);

   flags_t flag_reg;
   flags_t flag_calc;
   logic   cond_pass;
   logic   cond_undef;
   logic   issue;
   logic   take;
   logic   pc_src_c;
   logic   reg_write_c;
   logic   mem_write_c;
   logic   unused_bits;

   // Only the operand sign bits feed the overflow logic.
   assign unused_bits = ^{src_a[WIDTH-2:0], src_b[WIDTH-2:0]};

   cond_eval u_cond_eval (
      .cond    (cond_e'(cond)),
      .flags   (flag_reg),
      .cond_ex (cond_pass),
      .undef   (cond_undef)
   );

   // An instruction is "issued" when the stage advances and is not squashed;
   // it "takes effect" when its condition also passes.
   assign issue   = en & ~flush;
   assign take    = issue & cond_pass;
   assign cond_ex = cond_pass;
   assign undef   = cond_undef & issue;
   assign flags   = flag_reg;

   // Flag generation. Overflow compares sign bits: ADD overflows when both
   // operands share a sign the result lacks; SUB when the operands differ in
   // sign and the result's sign differs from A. Logical ops produce C=V=0.
   always_comb begin
      flag_calc.n = alu_result[WIDTH-1];
      flag_calc.z = (alu_result == '0);
      flag_calc.c = 1'b0;
      flag_calc.v = 1'b0;
      case (alu_ctrl_e'(alu_ctrl))
         ADD: begin
            flag_calc.c = alu_cout;
            flag_calc.v = (src_a[WIDTH-1] == src_b[WIDTH-1]) &
                          (alu_result[WIDTH-1] != src_a[WIDTH-1]);
         end
         SUB: begin
            flag_calc.c = alu_cout;
            flag_calc.v = (src_a[WIDTH-1] != src_b[WIDTH-1]) &
                          (alu_result[WIDTH-1] != src_a[WIDTH-1]);
         end
         default: begin
            flag_calc.c = 1'b0;
            flag_calc.v = 1'b0;
         end
      endcase
   end

   // Architectural flag register; the NZ and CV halves update independently.
   // No bypass: a write is seen by cond_eval only from the next cycle on.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flag_reg <= '0;
      end else if (take) begin
         if (flag_w[1]) begin
            flag_reg.n <= flag_calc.n;
            flag_reg.z <= flag_calc.z;
         end
         if (flag_w[0]) begin
            flag_reg.c <= flag_calc.c;
            flag_reg.v <= flag_calc.v;
         end
      end
   end

   // Annulled-instruction counter, including the reserved condition; it
   // sticks at all-ones rather than wrapping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         annul_cnt <= '0;
      end else if (issue && !cond_pass && (annul_cnt != {CNT_W{1'b1}})) begin
         annul_cnt <= annul_cnt + 1'b1;
      end
   end

   assign pc_src_c    = pcs & take;
   assign reg_write_c = reg_w & ~no_write & take;
   assign mem_write_c = mem_w & take;

   // Strobe output stage: either passed straight through or delayed one cycle
   // for Writeback timing. In the registered case flush clears the strobes
   // even during a stall, while a plain stall holds them.
   generate
      if (PIPE_OUT != 0) begin : g_pipe
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               pc_src    <= 1'b0;
               reg_write <= 1'b0;
               mem_write <= 1'b0;
            end else if (flush) begin
               pc_src    <= 1'b0;
               reg_write <= 1'b0;
               mem_write <= 1'b0;
            end else if (en) begin
               pc_src    <= pc_src_c;
               reg_write <= reg_write_c;
               mem_write <= mem_write_c;
            end
         end
      end else begin : g_comb
         assign pc_src    = pc_src_c;
         assign reg_write = reg_write_c;
         assign mem_write = mem_write_c;
      end
   endgenerate

endmodule
